// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencing front-end.
package alu_pkg;

  localparam int WIDTH     = 16;
  localparam int MUL_ITERS = 16;
  localparam int CNT_W     = 5;

  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    REQ_ADD  = 3'b000,
    REQ_SUB  = 3'b001,
    REQ_AND  = 3'b010,
    REQ_NOT  = 3'b011,
    REQ_CMP  = 3'b100,
    REQ_MUL  = 3'b101,
    REQ_RSV6 = 3'b110,
    REQ_RSV7 = 3'b111
  } req_op_t;

  typedef enum logic [2:0] {
    COND_AL = 3'b000,
    COND_EQ = 3'b001,
    COND_NE = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_MI = 3'b101,
    COND_VS = 3'b110,
    COND_NV = 3'b111
  } cond_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_RESP = 2'b10
  } ctrl_state_t;

  // CMP is a SUB whose result is only interesting for its flags.
  function automatic alu_op_t map_op(input req_op_t op);
    case (op)
      REQ_SUB, REQ_CMP: return ALU_SUB;
      REQ_AND:          return ALU_AND;
      REQ_NOT:          return ALU_NOT;
      default:          return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Branch condition evaluation from the committed {V,N,Z} flags.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] cond,
  output logic       cond_true
);

  logic v, n, z;

  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];

  always_comb begin
    cond_true = 1'b0;
    case (cond_t'(cond))
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_LT: cond_true = n ^ v;
      COND_GE: cond_true = ~(n ^ v);
      COND_MI: cond_true = n;
      COND_VS: cond_true = v;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Request/response sequencer around the 4-op ALU: flags register, CMP,
// and a 16-iteration shift-add unsigned MUL that reuses the ALU adder.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_setflags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [2:0]       alu_status,
  output logic [2:0]       flags,
  input  logic [2:0]       cond,
  output logic             cond_true
);

  ctrl_state_t      state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             setf_q, setf_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [2:0]       rsp_flags_q, rsp_flags_d;
  logic [2:0]       flags_q, flags_d;
  logic [2:0]       mul_flags;
  alu_op_t          alu_op_e;
  req_op_t          op;

  assign op = req_op_t'(req_op);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    setf_d       = setf_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    flags_d      = flags_q;
    mul_flags    = 3'b000;
    req_ready    = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_op_e     = ALU_ADD;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        alu_a     = req_a;
        alu_b     = req_b;
        alu_op_e  = map_op(op);
        if (req_valid) begin
          case (op)
            REQ_MUL: begin
              mcand_d  = req_a;
              mplier_d = req_b;
              acc_d    = '0;
              cnt_d    = '0;
              setf_d   = req_setflags;
              state_d  = ST_MUL;
            end
            REQ_RSV6, REQ_RSV7: begin
              rsp_result_d = '0;
              rsp_flags_d  = 3'b000;
              state_d      = ST_RESP;
            end
            default: begin
              rsp_result_d = alu_out;
              rsp_flags_d  = alu_status;
              if (req_setflags || op == REQ_CMP) flags_d = alu_status;
              state_d = ST_RESP;
            end
          endcase
        end
      end

      ST_MUL: begin
        alu_a    = acc_q;
        alu_b    = mplier_q[0] ? mcand_q : '0;
        acc_d    = alu_out;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The adder's overflow means nothing for a truncated product.
        mul_flags = {1'b0, alu_out[WIDTH-1], alu_out == '0};
        if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
          rsp_result_d = alu_out;
          rsp_flags_d  = mul_flags;
          if (setf_q) flags_d = mul_flags;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      setf_q       <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 3'b000;
      flags_q      <= 3'b000;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      cnt_q        <= cnt_d;
      setf_q       <= setf_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      flags_q      <= flags_d;
    end
  end

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign flags      = flags_q;
  assign alu_op     = alu_op_e;

  alu_cond_eval u_cond (
    .flags     (flags_q),
    .cond      (cond),
    .cond_true (cond_true)
  );

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU, transaction-level reference model,
// per-cycle comparison plus directed literal checks and random traffic.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_setflags;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [1:0]  alu_op;
  logic [2:0]  alu_status;
  logic [2:0]  flags;
  logic [2:0]  cond;
  logic        cond_true;

  int total = 0;
  int bad   = 0;
  bit rand_cond = 0;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_setflags(req_setflags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_status(alu_status),
    .flags(flags), .cond(cond), .cond_true(cond_true)
  );

  // Combinational ALU standing in for the real datapath.
  logic alu_v;
  always_comb begin
    alu_v = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_out = alu_a + alu_b;
        alu_v = (alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15]);
      end
      2'b01: begin
        alu_out = alu_a - alu_b;
        alu_v = (alu_a[15] != alu_b[15]) && (alu_out[15] != alu_a[15]);
      end
      2'b10:   alu_out = alu_a & alu_b;
      default: alu_out = ~alu_a;
    endcase
    alu_status = {alu_v, alu_out[15], alu_out == 16'h0000};
  end

  // Expected {flags,result} of one request, straight from the op definitions.
  function automatic logic [18:0] ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [31:0] p;
    logic v;
    v = 1'b0;
    case (op)
      3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd1, 3'd4: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd2: r = a & b;
      3'd3: r = ~a;
      3'd5: begin p = {16'h0, a} * {16'h0, b}; r = p[15:0]; end
      default: return 19'd0;
    endcase
    return {v, r[15], r == 16'h0000, r};
  endfunction

  function automatic logic cond_ref(input logic [2:0] f, input logic [2:0] c);
    logic v, n, z;
    {v, n, z} = f;
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n != v;
      3'd4: return n == v;
      3'd5: return n;
      3'd6: return v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference model.
  bit          m_busy, m_valid, m_commit;
  int          m_wait;
  logic [15:0] m_res;
  logic [2:0]  m_rfl, m_flags;
  wire  [18:0] m_now = ref_op(req_op, req_a, req_b);
  wire         m_cmt_now = (req_op <= 3'd5) && (req_setflags || req_op == 3'd4);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_valid <= 0; m_commit <= 0; m_wait <= 0;
      m_res <= '0; m_rfl <= '0; m_flags <= '0;
    end else if (m_valid) begin
      if (rsp_ready) begin m_valid <= 0; m_busy <= 0; end
    end else if (m_busy) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_valid <= 1;
        if (m_commit) m_flags <= m_rfl;
      end
    end else if (req_valid) begin
      m_busy   <= 1;
      m_res    <= m_now[15:0];
      m_rfl    <= m_now[18:16];
      m_commit <= m_cmt_now;
      if (req_op == 3'd5) m_wait <= 16;
      else begin
        m_valid <= 1;
        if (m_cmt_now) m_flags <= m_now[18:16];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", req_ready, !m_busy);
      chk("rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_flags", rsp_flags, m_rfl);
      end
      chk("flags", flags, m_flags);
      chk("cond_true", cond_true, cond_ref(m_flags, cond));
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rand_cond) cond = 3'($urandom_range(0, 7));
  end

  task automatic accept_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic sf, output bit ok);
    ok = 0;
    req_op = op; req_a = a; req_b = b; req_setflags = sf; req_valid = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    req_valid = 0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic sf, input int hold,
                      output int lat, output logic [15:0] res, output logic [2:0] fl);
    bit ok;
    accept_req(op, a, b, sf, ok);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = rsp_result;
    fl  = rsp_flags;
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready = 1;
    @(posedge clk);
    #1;
    rsp_ready = 0;
  endtask

  task automatic summary();
    $display("test done: total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    #1000000;
    chk("watchdog", 0, 1);
    summary();
    $finish;
  end

  initial begin
    int          lat;
    logic [15:0] res, a, b;
    logic [2:0]  fl, op;
    bit          ok;

    rst = 1; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_setflags = 0;
    rsp_ready = 0; cond = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_flags", flags, 0);
    rst = 0;
    @(posedge clk); #1;

    send(3'd0, 16'h7FFF, 16'h0001, 1, 0, lat, res, fl);
    chk("add_lat", lat, 1);
    chk("add_res", res, 16'h8000);
    chk("add_fl", fl, 3'b110);
    chk("add_flags", flags, 3'b110);
    cond = 3'd3; #1 chk("add_lt", cond_true, 0);
    cond = 3'd5; #1 chk("add_mi", cond_true, 1);

    send(3'd1, 16'h0005, 16'h0003, 0, 0, lat, res, fl);
    chk("sub_res", res, 16'h0002);
    chk("sub_fl", fl, 3'b000);
    chk("sub_flags_kept", flags, 3'b110);

    send(3'd4, 16'h0005, 16'h0005, 0, 0, lat, res, fl);
    chk("cmp_res", res, 16'h0000);
    chk("cmp_flags", flags, 3'b001);
    cond = 3'd1; #1 chk("cmp_eq", cond_true, 1);
    cond = 3'd2; #1 chk("cmp_ne", cond_true, 0);

    send(3'd5, 16'h0003, 16'h0005, 0, 0, lat, res, fl);
    chk("mul_lat", lat, 17);
    chk("mul_res", res, 16'h000F);
    chk("mul_fl", fl, 3'b000);
    chk("mul_flags_kept", flags, 3'b001);

    send(3'd0, 16'h7FFF, 16'h0001, 1, 0, lat, res, fl);
    send(3'd5, 16'h0100, 16'h0100, 1, 0, lat, res, fl);
    chk("mul2_res", res, 16'h0000);
    chk("mul2_flags", flags, 3'b001);

    // Backpressure with a second request waiting.
    accept_req(3'd0, 16'h1234, 16'h1111, 0, ok);
    req_op = 3'd1; req_a = 16'h0009; req_b = 16'h0004; req_setflags = 0; req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_ready", req_ready, 0);
      chk("bp_res", rsp_result, 16'h2345);
      chk("bp_fl", rsp_flags, 3'b000);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("bp_after_hs_ready", req_ready, 1);
    chk("bp_after_hs_valid", rsp_valid, 0);
    @(posedge clk); #1;
    req_valid = 0;
    chk("bp_second_valid", rsp_valid, 1);
    chk("bp_second_res", rsp_result, 16'h0005);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;

    // Reset in the middle of a MUL.
    accept_req(3'd5, 16'h1234, 16'h0003, 1, ok);
    repeat (8) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mrst_valid", rsp_valid, 0);
    chk("mrst_ready", req_ready, 1);
    chk("mrst_flags", flags, 0);
    @(posedge clk); #1 rst = 0;
    repeat (20) @(posedge clk);
    #1 chk("mrst_no_rsp", rsp_valid, 0);
    send(3'd0, 16'hFFFF, 16'h0001, 1, 0, lat, res, fl);
    chk("mrst_add_res", res, 16'h0000);
    chk("mrst_add_flags", flags, 3'b001);

    rand_cond = 1;
    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = (($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000);
      if ($urandom_range(0, 3) == 0) b = (($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000);
      send(op, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), lat, res, fl);
      chk("rand_lat", lat, (op == 3'd5) ? 17 : 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_cond = 0;

    repeat (3) @(posedge clk);
    summary();
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
Sequencing front-end for the 16-bit, 4-operation combinational ALU. It accepts operation requests over a valid/ready handshake and drives the ALU operand and op inputs. It captures the ALU result and status, holds the architectural flags register (V,N,Z), and evaluates branch conditions from those flags. It adds CMP and a multicycle unsigned MUL, built as 16 shift-add iterations through the ALU's ADD.

Parameters:
WIDTH, 16, datapath width; fixed to match the ALU. No other value is supported.

Ports:
clk  in  1  system clock; everything is rising-edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_op  in  3  request opcode: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 CMP, 101 MUL, 110/111 reserved.
req_a  in  16  operand A.
req_b  in  16  operand B; ignored for NOT.
req_setflags  in  1  commit this op's flags to the flags register. CMP always commits.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_result  out  16  operation result.
rsp_flags  out  3  {V,N,Z} produced by this op, whether or not it was committed.
alu_a  out  16  to ALU a_in.
alu_b  out  16  to ALU b_in.
alu_op  out  2  to ALU op: 00 ADD, 01 SUB, 10 AND, 11 NOT.
alu_out  in  16  from ALU out.
alu_status  in  3  from ALU status, {V,N,Z}.
flags  out  3  architectural flags register {V,N,Z}.
cond  in  3  condition select: 000 AL, 001 EQ (Z), 010 NE (!Z), 011 LT (N^V), 100 GE (!(N^V)), 101 MI (N), 110 VS (V), 111 NV (0).
cond_true  out  1  combinational result of cond evaluated on flags.

Behaviour:
- Reset (async, active-high): state IDLE; rsp_valid=0, rsp_result=0, rsp_flags=0, flags=0; iteration counter and MUL registers cleared. Reset during MUL or RESP aborts the operation; no response is produced.
- States are IDLE, MUL and RESP.
- IDLE:
  - req_ready=1; the ALU is driven combinationally from req_a, req_b and the mapped req_op.
  - Handshake fires on req_valid & req_ready at edge T.
  - ADD, SUB, AND, NOT, CMP: alu_out and alu_status are registered into rsp_result and rsp_flags; go to RESP. rsp_valid=1 from cycle T+1. CMP maps to SUB.
  - MUL: load mcand=req_a, mplier=req_b, acc=0, count=0; go to MUL.
  - Reserved op: rsp_result=0 and rsp_flags=000; go to RESP; flags never updated.
- MUL:
  - req_ready=0; alu_op=00; alu_a=acc; alu_b = mplier[0] ? mcand : 0.
  - Each cycle: acc<=alu_out; mcand<<=1 (bits beyond 15 dropped); mplier>>=1; count++.
  - After 16 iterations: rsp_result=acc, i.e. the low 16 bits of the unsigned product.
  - MUL flags are Z=(result==0), N=result[15], V=0; the ALU's V is ignored.
  - Go to RESP. Accept at edge T gives rsp_valid=1 from cycle T+17.
- RESP:
  - rsp_valid=1; req_ready=0; ALU driven with a=0, b=0, op=00.
  - rsp_result and rsp_flags stay stable until rsp_valid & rsp_ready, then return to IDLE. A new request is accepted no earlier than the following cycle, so there is no overlap.
- Flags commit happens on the edge that enters RESP, when req_setflags=1 (latched at accept) or op=CMP. Otherwise flags are unchanged.
- cond_true reflects the committed flags only, visible from the cycle after the commit.
- Requests are never dropped; backpressure is held indefinitely.

Decomposition:
- Package alu_pkg:
  - WIDTH.
  - alu_op_t enum: ADD, SUB, AND, NOT.
  - req_op_t enum (3-bit).
  - cond_t enum.
  - Flag index constants FLAG_V=2, FLAG_N=1, FLAG_Z=0.
  - ctrl_state_t enum: IDLE, MUL, RESP.
- One sub-module, alu_cond_eval: combinational mapping of (flags, cond) to cond_true.

Test Plan:
- Reset, then ADD 0x7FFF+0x0001 with setflags=1 -> rsp_valid at T+1; rsp_result=0x8000; rsp_flags=flags=3'b110; cond=LT gives cond_true=0; cond=MI gives 1.
- CMP 0x0005,0x0005 with setflags=0 -> rsp_result=0x0000; flags=3'b001; EQ gives cond_true=1; NE gives 0.
- SUB 0x0005-0x0003 with setflags=0 after the first test -> rsp_result=0x0002; rsp_flags=3'b000; flags remain 3'b110.
- MUL 0x0003*0x0005 -> rsp_valid exactly 17 cycles after accept; result 0x000F; flags 000. MUL 0x0100*0x0100 with setflags=1 -> result 0x0000; flags=3'b001.
- rsp_ready held low 5 cycles with req_valid=1 -> rsp_result and rsp_flags stable; req_ready=0; the second request is accepted only after the response handshake plus one cycle.
- rst asserted at MUL iteration 8 -> immediately IDLE; rsp_valid stays 0; flags=000; the next ADD request completes normally.
